// File: rtl/vga_timing_pkg.sv
// Shared raster types, XGA 1024x768@60 timing defaults and total-size helpers
// for vga_timing_gen.
package vga_timing_pkg;

    typedef logic [10:0] hcount_t;
    typedef logic [9:0]  vcount_t;

    localparam int unsigned XGA_H_ACTIVE = 1024;
    localparam int unsigned XGA_H_FP     = 24;
    localparam int unsigned XGA_H_SYNC   = 136;
    localparam int unsigned XGA_H_BP     = 160;
    localparam int unsigned XGA_V_ACTIVE = 768;
    localparam int unsigned XGA_V_FP     = 3;
    localparam int unsigned XGA_V_SYNC   = 6;
    localparam int unsigned XGA_V_BP     = 29;

    // XGA syncs are negative polarity
    localparam logic SYNC_ACT_DEFAULT = 1'b0;

    function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Enabled modulo-(MAX+1) counter; exposes the registered count, the value it
// will take on the next edge, and a wrap pulse for cascading.
module wrap_counter #(
    parameter int unsigned W   = 8,
    parameter int unsigned MAX = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] next_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] MAX_C = MAX[W-1:0];

    logic [W-1:0] count_q, count_d;

    always_comb begin
        wrap_o  = en_i && (count_q == MAX_C);
        count_d = count_q;
        if (wrap_o)
            count_d = '0;
        else if (en_i)
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;
    assign next_o  = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: h/v counters plus registered sync/blank/frame_start decode.
// Optional frame_count output when VGA_TIMING_FRAME_COUNT_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = XGA_H_ACTIVE,
    parameter int unsigned H_FP     = XGA_H_FP,
    parameter int unsigned H_SYNC   = XGA_H_SYNC,
    parameter int unsigned H_BP     = XGA_H_BP,
    parameter int unsigned V_ACTIVE = XGA_V_ACTIVE,
    parameter int unsigned V_FP     = XGA_V_FP,
    parameter int unsigned V_SYNC   = XGA_V_SYNC,
    parameter int unsigned V_BP     = XGA_V_BP,
    parameter logic        SYNC_ACT = SYNC_ACT_DEFAULT
) (
    input  logic        system_clock_in,
    input  logic        reset_in,
    input  logic        pix_en,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam hcount_t H_ACT_C  = hcount_t'(H_ACTIVE);
    localparam hcount_t HS_START = hcount_t'(H_ACTIVE + H_FP);
    localparam hcount_t HS_END   = hcount_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam vcount_t V_ACT_C  = vcount_t'(V_ACTIVE);
    localparam vcount_t VS_START = vcount_t'(V_ACTIVE + V_FP);
    localparam vcount_t VS_END   = vcount_t'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL > 2048) begin : g_h_chk
            $error("vga_timing_gen: H_TOTAL exceeds 11-bit hcount range");
        end
        if (V_TOTAL > 1024) begin : g_v_chk
            $error("vga_timing_gen: V_TOTAL exceeds 10-bit vcount range");
        end
    endgenerate

    hcount_t h_q, h_d;
    vcount_t v_q, v_d;
    logic    h_wrap, v_wrap;

    wrap_counter #(.W(11), .MAX(H_TOTAL - 1)) u_hcnt (
        .clk_i   (system_clock_in),
        .rst_i   (reset_in),
        .en_i    (pix_en),
        .count_o (h_q),
        .next_o  (h_d),
        .wrap_o  (h_wrap)
    );

    wrap_counter #(.W(10), .MAX(V_TOTAL - 1)) u_vcnt (
        .clk_i   (system_clock_in),
        .rst_i   (reset_in),
        .en_i    (pix_en & h_wrap),
        .count_o (v_q),
        .next_o  (v_d),
        .wrap_o  (v_wrap)
    );

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic blank_q, blank_d;
    logic fs_q, fs_d;

    // Decode the next counter values so the registered flags line up with the
    // counters they describe.
    always_comb begin
        hsync_d = ((h_d >= HS_START) && (h_d < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
        vsync_d = ((v_d >= VS_START) && (v_d < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
        blank_d = (h_d >= H_ACT_C) || (v_d >= V_ACT_C);
        fs_d    = v_wrap;
    end

    always_ff @(posedge system_clock_in) begin
        if (reset_in) begin
            hsync_q <= ~SYNC_ACT;
            vsync_q <= ~SYNC_ACT;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d;
            fs_q    <= fs_d;
        end
    end

    assign hcount      = h_q;
    assign vcount      = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign frame_start = fs_q;

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] fc_q, fc_d;

    always_comb fc_d = v_wrap ? fc_q + 16'd1 : fc_q;

    always_ff @(posedge system_clock_in) begin
        if (reset_in)
            fc_q <= '0;
        else
            fc_q <= fc_d;
    end

    assign frame_count = fc_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: an XGA instance and a reduced-geometry instance share
// stimulus; a scoreboard queue feeds a negedge monitor, plus directed boundary checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] hc_s, hc_x;
    logic [9:0]  vc_s, vc_x;
    logic        hs_s, vs_s, bl_s, fs_s;
    logic        hs_x, vs_x, bl_x, fs_x;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] fc_s, fc_x;
`endif

    // small: H_TOTAL=25 (hsync h 18..21), V_TOTAL=13 (vsync v 9..10)
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .system_clock_in(clk), .reset_in(rst), .pix_en(en),
        .hcount(hc_s), .vcount(vc_s), .hsync(hs_s), .vsync(vs_s),
        .blank(bl_s), .frame_start(fs_s)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frame_count(fc_s)
`endif
    );

    vga_timing_gen u_xga (
        .system_clock_in(clk), .reset_in(rst), .pix_en(en),
        .hcount(hc_x), .vcount(vc_x), .hsync(hs_x), .vsync(vs_x),
        .blank(bl_x), .frame_start(fs_x)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frame_count(fc_x)
`endif
    );

    typedef struct {int ha; int hfp; int hsw; int hbp; int va; int vfp; int vsw; int vbp;} geom_t;
    typedef struct {int h; int v; bit fs;} st_t;
    typedef struct packed {logic [24:0] s; logic [24:0] x;} pair_t;

    geom_t gs, gx;
    st_t   ss, sx;
    pair_t q[$];

    int total = 0;
    int bad   = 0;

    // monitor observations
    int hs_min = 99999, hs_max = -1;
    int br_min = 99999, br_max = -1;
    int vs_min = 99999, vs_max = -1;
    int fs_cnt_s = 0;
    logic prev_bl_x = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic st_t mstep(input st_t s, input geom_t g, input logic r, input logic e);
        st_t n;
        n = s;
        n.fs = 1'b0;
        if (r) begin
            n.h = 0;
            n.v = 0;
        end else if (e) begin
            n.h = s.h + 1;
            if (n.h == g.ha + g.hfp + g.hsw + g.hbp) begin
                n.h = 0;
                n.v = s.v + 1;
                if (n.v == g.va + g.vfp + g.vsw + g.vbp) begin
                    n.v  = 0;
                    n.fs = 1'b1;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [24:0] mpack(input st_t s, input geom_t g);
        logic hs, vs, bl;
        hs = !(s.h >= g.ha + g.hfp && s.h < g.ha + g.hfp + g.hsw);
        vs = !(s.v >= g.va + g.vfp && s.v < g.va + g.vfp + g.vsw);
        bl = (s.h >= g.ha) || (s.v >= g.va);
        return {s.h[10:0], s.v[9:0], hs, vs, bl, s.fs};
    endfunction

    task automatic step(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
        ss = mstep(ss, gs, r, e);
        sx = mstep(sx, gx, r, e);
        q.push_back(pair_t'({mpack(ss, gs), mpack(sx, gx)}));
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // scoreboard monitor
    initial begin
        pair_t p;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                p = q.pop_front();
                chk("sb_small", {hc_s, vc_s, hs_s, vs_s, bl_s, fs_s}, p.s);
                chk("sb_xga",   {hc_x, vc_x, hs_x, vs_x, bl_x, fs_x}, p.x);
                if (hs_x == 1'b0) begin
                    if (int'(hc_x) < hs_min) hs_min = int'(hc_x);
                    if (int'(hc_x) > hs_max) hs_max = int'(hc_x);
                end
                if (bl_x && !prev_bl_x) begin
                    if (int'(hc_x) < br_min) br_min = int'(hc_x);
                    if (int'(hc_x) > br_max) br_max = int'(hc_x);
                end
                prev_bl_x = bl_x;
                if (vs_s == 1'b0) begin
                    if (int'(vc_s) < vs_min) vs_min = int'(vc_s);
                    if (int'(vc_s) > vs_max) vs_max = int'(vc_s);
                end
                if (fs_s) fs_cnt_s++;
            end
        end
    end

    initial begin
        int f0;
        gs = '{16, 2, 4, 3, 8, 1, 2, 2};
        gx = '{1024, 24, 136, 160, 768, 3, 6, 29};
        ss = '{0, 0, 1'b0};
        sx = '{0, 0, 1'b0};

        repeat (3) step(1'b1, 1'b1);
        chk("rst_small", {hc_s, vc_s, hs_s, vs_s, bl_s, fs_s}, {11'd0, 10'd0, 4'b1100});
        chk("rst_xga",   {hc_x, vc_x, hs_x, vs_x, bl_x, fs_x}, {11'd0, 10'd0, 4'b1100});

        // one XGA line from reset
        for (int i = 1; i <= 1344; i++) begin
            step(1'b0, 1'b1);
            if (i == 1023) chk("xga_last_active", {hc_x, bl_x}, {11'd1023, 1'b0});
            if (i == 1343) chk("xga_line_end", {hc_x, vc_x}, {11'd1343, 10'd0});
        end
        chk("xga_line_wrap", {hc_x, vc_x, fs_x}, {11'd0, 10'd1, 1'b0});
        settle();
        chk("xga_blank_rise_min", br_min, 1024);
        chk("xga_blank_rise_max", br_max, 1024);
        chk("xga_hsync_first", hs_min, 1048);
        chk("xga_hsync_last", hs_max, 1183);

        // full small frame from reset
        step(1'b1, 1'b1);
        settle();
        f0 = fs_cnt_s;
        for (int i = 1; i <= 325; i++) begin
            step(1'b0, 1'b1);
            if (i == 175) chk("small_v7_active", {vc_s, bl_s}, {10'd7, 1'b0});
            if (i == 191) chk("small_h16_blank", {hc_s, bl_s}, {11'd16, 1'b1});
            if (i == 200) chk("small_v8_blank", {hc_s, vc_s, bl_s}, {11'd0, 10'd8, 1'b1});
            if (i == 324) chk("small_last_pix", {hc_s, vc_s, fs_s}, {11'd24, 10'd12, 1'b0});
        end
        chk("small_frame_end", {hc_s, vc_s, fs_s}, {11'd0, 10'd0, 1'b1});
        settle();
        chk("small_fs_once", fs_cnt_s - f0, 1);
        chk("small_vsync_first", vs_min, 9);
        chk("small_vsync_last", vs_max, 10);

        // pix_en toggling: 650 cycles for one small frame
        f0 = fs_cnt_s;
        for (int i = 1; i <= 650; i++) begin
            step(1'b0, i[0]);
            if (i == 2)   chk("tog_h1", {hc_s, vc_s}, {11'd1, 10'd0});
            if (i == 648) chk("tog_pre_wrap", {hc_s, vc_s, fs_s}, {11'd24, 10'd12, 1'b0});
            if (i == 649) chk("tog_wrap", {hc_s, vc_s, fs_s}, {11'd0, 10'd0, 1'b1});
            if (i == 650) chk("tog_hold", {hc_s, vc_s, fs_s}, {11'd0, 10'd0, 1'b0});
        end
        settle();
        chk("tog_fs_once", fs_cnt_s - f0, 1);

        // mid-frame reset
        repeat (135) step(1'b0, 1'b1);
        chk("mid_pos", {hc_s, vc_s}, {11'd10, 10'd5});
        step(1'b1, 1'b1);
        chk("mid_rst_small", {hc_s, vc_s, hs_s, vs_s, bl_s, fs_s}, {11'd0, 10'd0, 4'b1100});
        chk("mid_rst_xga",   {hc_x, vc_x, hs_x, vs_x, bl_x, fs_x}, {11'd0, 10'd0, 4'b1100});

        // three small frames
        settle();
        f0 = fs_cnt_s;
        repeat (975) step(1'b0, 1'b1);
        settle();
        chk("three_frames_fs", fs_cnt_s - f0, 3);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        chk("frame_count_small", fc_s, 16'd3);
        chk("frame_count_xga", fc_x, 16'd0);
`endif
        settle();
        chk("sb_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
